mult_arb2: RTL

Two-port round-robin arbiter and result router that shares one pipelined `mult32x32` instance between two requesters. It accepts operand requests on independent valid/ready ports and issues at most one multiply per cycle. A tag pipeline tracks each product in flight, and each product is returned in order to the requester that issued it, through a per-requester result FIFO with credit-based flow control. The block sits between the MAC/ALU issue logic and the multiplier datapath.

---
 rtl/mult_arb2.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_arb2.sv
// Shares one pipelined multiplier between two requesters: round-robin issue, MULT_LAT-cycle latency,
// in-order per-requester results; requests stall on credit (in-flight + queued >= FIFO_DEPTH).
module mult_arb2_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];

  // Credit accounting upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (cnt == CW'(DEPTH))));
endmodule

module mult_arb2 #(
  parameter int MULT_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req0_vld,
  output logic        o_req0_rdy,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [1:0]  i_req0_ns,
  input  logic        i_req1_vld,
  output logic        o_req1_rdy,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [1:0]  i_req1_ns,
  output logic        o_rsp0_vld,
  input  logic        i_rsp0_rdy,
  output logic [63:0] o_rsp0_p,
  output logic        o_rsp1_vld,
  input  logic        i_rsp1_rdy,
  output logic [63:0] o_rsp1_p,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  output logic        o_mul_a_ns,
  output logic        o_mul_b_ns,
  input  logic [63:0] i_mul_p,
  output logic        o_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [CW-1:0]       outst0, outst1, cnt0, cnt1;
  logic [SW-1:0]       used0, used1;
  logic                elig0, elig1, cand0, cand1;
  logic                grant0, grant1, grant, ptr;
  logic [MULT_LAT-1:0] tag_vld, tag_id;
  logic                wb, push0, push1, pop0, pop1;

  // Eligibility is built only from registered counters, never from rsp ready.
  assign used0 = SW'(outst0) + SW'(cnt0);
  assign used1 = SW'(outst1) + SW'(cnt1);
  assign elig0 = used0 < SW'(FIFO_DEPTH);
  assign elig1 = used1 < SW'(FIFO_DEPTH);
  assign cand0 = i_req0_vld & elig0;
  assign cand1 = i_req1_vld & elig1;

  assign o_req0_rdy = i_rstn & elig0 & (~cand1 | (cand0 & ~ptr));
  assign o_req1_rdy = i_rstn & elig1 & (~cand0 | (cand1 & ptr));
  assign grant0     = i_req0_vld & o_req0_rdy;
  assign grant1     = i_req1_vld & o_req1_rdy;
  assign grant      = grant0 | grant1;

  assign wb    = tag_vld[MULT_LAT-1];
  assign push0 = wb & ~tag_id[MULT_LAT-1];
  assign push1 = wb & tag_id[MULT_LAT-1];
  assign pop0  = o_rsp0_vld & i_rsp0_rdy;
  assign pop1  = o_rsp1_vld & i_rsp1_rdy;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr        <= 1'b0;
      tag_vld    <= '0;
      tag_id     <= '0;
      outst0     <= '0;
      outst1     <= '0;
      o_mul_a    <= '0;
      o_mul_b    <= '0;
      o_mul_a_ns <= 1'b0;
      o_mul_b_ns <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      tag_vld[0] <= grant;
      tag_id[0]  <= grant1;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      if (grant) begin
        ptr        <= grant0;  // priority passes to the side that did not win
        o_mul_a    <= grant1 ? i_req1_a : i_req0_a;
        o_mul_b    <= grant1 ? i_req1_b : i_req0_b;
        o_mul_a_ns <= grant1 ? i_req1_ns[1] : i_req0_ns[1];
        o_mul_b_ns <= grant1 ? i_req1_ns[0] : i_req0_ns[0];
      end
      outst0 <= outst0 + CW'(grant0) - CW'(push0);
      outst1 <= outst1 + CW'(grant1) - CW'(push1);
      o_busy <= (|tag_vld) | (cnt0 != '0) | (cnt1 != '0);
    end
  end

  mult_arb2_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo0 (
    .clk(i_clk), .rst_n(i_rstn), .push(push0), .pop(pop0),
    .din(i_mul_p), .dout(o_rsp0_p), .cnt(cnt0)
  );

  mult_arb2_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo1 (
    .clk(i_clk), .rst_n(i_rstn), .push(push1), .pop(pop1),
    .din(i_mul_p), .dout(o_rsp1_p), .cnt(cnt1)
  );

  assign o_rsp0_vld = cnt0 != '0;
  assign o_rsp1_vld = cnt1 != '0;
endmodule
